// File: rtl/input_debouncer.sv
// Input conditioning for the board switches and buttons.
// Each channel has a 2-flop synchronizer and a tick-driven stability filter.
// A new level is accepted only after STABLE_TICKS consecutive sample ticks
// that all disagree with the current output. The block also produces
// registered rise and fall pulses on every accepted change.
module input_debouncer #(
  parameter int unsigned      WIDTH        = 4,
  parameter int unsigned      STABLE_TICKS = 8,
  parameter int unsigned      COUNT_W      = 4,
  parameter logic [WIDTH-1:0] RESET_LEVEL  = '0
) (
  input  logic             clock,
  input  logic             reset_pulse,
  input  logic             sample_tick,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed
);

  typedef enum logic {
    ST_STABLE,
    ST_CONFIRM
  } state_t;

  // Count value on which the next disagreeing tick commits the new level.
  localparam logic [COUNT_W-1:0] LAST_CNT = COUNT_W'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]   sync1;
  logic [WIDTH-1:0]   sync2;
  state_t             state_q [WIDTH];
  state_t             state_d [WIDTH];
  logic [COUNT_W-1:0] cnt_q   [WIDTH];
  logic [COUNT_W-1:0] cnt_d   [WIDTH];
  logic [WIDTH-1:0]   level_d;
  logic [WIDTH-1:0]   rise_d;
  logic [WIDTH-1:0]   fall_d;
  logic               commit;

  // Two-flop synchronizer; it samples on every clock, whatever the tick does.
  always_ff @(posedge clock or negedge reset_pulse) begin
    if (!reset_pulse) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Per-channel filter state and stability counter.
  always_ff @(posedge clock or negedge reset_pulse) begin
    if (!reset_pulse) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Registered level, edge pulses and the summary change flag.
  always_ff @(posedge clock or negedge reset_pulse) begin
    if (!reset_pulse) begin
      level_out  <= RESET_LEVEL;
      rise_pulse <= '0;
      fall_pulse <= '0;
      changed    <= 1'b0;
    end else begin
      level_out  <= level_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      changed    <= |(rise_d | fall_d);
    end
  end

  // Next-state logic. A commit flips the level, arms one pulse bit and
  // returns the channel to STABLE with a cleared counter.
  always_comb begin
    level_d = level_out;
    rise_d  = '0;
    fall_d  = '0;
    commit  = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      commit     = 1'b0;
      if (sample_tick) begin
        unique case (state_q[i])
          ST_STABLE: begin
            if (sync2[i] != level_out[i]) begin
              if (STABLE_TICKS == 1) begin
                commit = 1'b1;
              end else begin
                cnt_d[i]   = COUNT_W'(1);
                state_d[i] = ST_CONFIRM;
              end
            end
          end
          ST_CONFIRM: begin
            if (sync2[i] == level_out[i]) begin
              cnt_d[i]   = '0;
              state_d[i] = ST_STABLE;
            end else if (cnt_q[i] == LAST_CNT) begin
              commit = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + COUNT_W'(1);
            end
          end
          default: begin
            cnt_d[i]   = '0;
            state_d[i] = ST_STABLE;
          end
        endcase
      end
      if (commit) begin
        level_d[i] = ~level_out[i];
        rise_d[i]  = ~level_out[i];
        fall_d[i]  = level_out[i];
        cnt_d[i]   = '0;
        state_d[i] = ST_STABLE;
      end
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: a 4-channel instance with 8-tick filtering and a
// tick every 4th clock, plus a 1-channel instance with 1-tick filtering and a
// tick that is always high.
module tb_input_debouncer;

  logic       clock = 1'b0;
  logic       reset_pulse;
  logic       tick_a;
  logic       tick_b;
  logic [3:0] raw_a;
  logic [0:0] raw_b;
  logic [3:0] level_a, rise_a, fall_a;
  logic [0:0] level_b, rise_b, fall_b;
  logic       changed_a, changed_b;

  input_debouncer #(
    .WIDTH(4), .STABLE_TICKS(8), .COUNT_W(4), .RESET_LEVEL(4'b0000)
  ) dut_a (
    .clock(clock), .reset_pulse(reset_pulse), .sample_tick(tick_a),
    .raw_in(raw_a), .level_out(level_a), .rise_pulse(rise_a),
    .fall_pulse(fall_a), .changed(changed_a)
  );

  input_debouncer #(
    .WIDTH(1), .STABLE_TICKS(1), .COUNT_W(1), .RESET_LEVEL(1'b0)
  ) dut_b (
    .clock(clock), .reset_pulse(reset_pulse), .sample_tick(tick_b),
    .raw_in(raw_b), .level_out(level_b), .rise_pulse(rise_b),
    .fall_pulse(fall_b), .changed(changed_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] rise;
    logic [3:0] fall;
  } ev_t;

  typedef struct {
    logic [3:0]  raw;
    int unsigned ticks;
    logic [3:0]  level;
    logic [3:0]  rise;
    logic [3:0]  fall;
  } vec_t;

  ev_t         q_a[$];
  ev_t         q_b[$];
  vec_t        vecs[13];
  int          total = 0;
  int          bad = 0;
  int unsigned phase = 0;
  bit          tick_en = 1'b1;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge, then drive the tick.
  // Any pulse seen must match the oldest expected event of that instance.
  task automatic cyc();
    ev_t e;
    @(posedge clock);
    #1;
    phase  = (phase + 1) % 4;
    tick_a = tick_en && (phase == 3);
    if (mon_en) begin
      if (rise_a != 0 || fall_a != 0 || changed_a) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_pulse", 16'({changed_a, rise_a, fall_a}), 16'h0);
        end else begin
          e = q_a.pop_front();
          check("a_pulse", 16'({changed_a, rise_a, fall_a}), 16'({1'b1, e.rise, e.fall}));
        end
      end
      if (rise_b != 0 || fall_b != 0 || changed_b) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_pulse", 16'({changed_b, rise_b, fall_b}), 16'h0);
        end else begin
          e = q_b.pop_front();
          check("b_pulse", 16'({changed_b, rise_b, fall_b}), 16'({1'b1, e.rise[0], e.fall[0]}));
        end
      end
    end
  endtask

  // Return just after a clock edge that sampled tick_a high.
  task automatic align();
    bit   ok;
    logic was;
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      was = tick_a;
      cyc();
      if (was) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("tick_align_timeout", 16'(ok), 16'h1);
  endtask

  initial begin
    logic [0:0] old_b;

    vecs[0]  = '{4'b0011, 7, 4'b0010, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0010, 1, 4'b0010, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0011, 8, 4'b0011, 4'b0001, 4'b0000};
    vecs[3]  = '{4'b1011, 8, 4'b1011, 4'b1000, 4'b0000};
    vecs[4]  = '{4'b0111, 8, 4'b0111, 4'b0100, 4'b1000};
    vecs[5]  = '{4'b0000, 8, 4'b0000, 4'b0000, 4'b0111};
    vecs[6]  = '{4'b0101, 3, 4'b0000, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b0101, 5, 4'b0101, 4'b0101, 4'b0000};
    vecs[8]  = '{4'b1010, 8, 4'b1010, 4'b1010, 4'b0101};
    vecs[9]  = '{4'b0000, 4, 4'b1010, 4'b0000, 4'b0000};
    vecs[10] = '{4'b1010, 2, 4'b1010, 4'b0000, 4'b0000};
    vecs[11] = '{4'b0000, 8, 4'b0000, 4'b0000, 4'b1010};
    vecs[12] = '{4'b0010, 8, 4'b0010, 4'b0010, 4'b0000};

    reset_pulse = 1'b1;
    raw_a       = 4'b1111;
    raw_b       = 1'b0;
    tick_a      = 1'b0;
    tick_b      = 1'b1;
    repeat (3) cyc();

    // Reset values, then a quiet release.
    reset_pulse = 1'b0;
    #1;
    mon_en = 1'b1;
    check("rst_level_a", 16'(level_a), 16'h0);
    check("rst_outs_a", 16'({changed_a, rise_a, fall_a}), 16'h0);
    check("rst_level_b", 16'(level_b), 16'h0);
    repeat (3) cyc();
    check("rst_hold_level_a", 16'(level_a), 16'h0);
    raw_a       = 4'b0000;
    reset_pulse = 1'b1;
    repeat (50) cyc();
    check("post_rst_level_a", 16'(level_a), 16'h0);

    // Clean edge on channel 1: ticks land 4, 8, ... 32 clocks after the change.
    align();
    raw_a = 4'b0010;
    q_a.push_back('{rise: 4'b0010, fall: 4'b0000});
    repeat (31) cyc();
    check("edge_early", 16'(level_a), 16'h0);
    cyc();
    check("edge_commit", 16'(level_a), 16'h2);
    repeat (3) cyc();
    check("edge_after", 16'(level_a), 16'h2);

    // Table: glitches, simultaneous rise/fall, split counts.
    align();
    for (int r = 0; r < 13; r++) begin
      raw_a = vecs[r].raw;
      if (vecs[r].rise != 0 || vecs[r].fall != 0)
        q_a.push_back('{rise: vecs[r].rise, fall: vecs[r].fall});
      repeat (vecs[r].ticks * 4) cyc();
      check($sformatf("vec%0d_level", r), 16'(level_a), 16'(vecs[r].level));
    end

    // Reset in the middle of a count: both raised channels restart together.
    raw_a = 4'b0011;
    repeat (20) cyc();
    reset_pulse = 1'b0;
    #1;
    check("mid_rst_level", 16'(level_a), 16'h0);
    cyc();
    reset_pulse = 1'b1;
    q_a.push_back('{rise: 4'b0011, fall: 4'b0000});
    repeat (30) cyc();
    check("mid_rst_early", 16'(level_a), 16'h0);
    cyc();
    check("mid_rst_commit", 16'(level_a), 16'h3);

    // Tick held low: level is frozen whatever raw does.
    tick_en = 1'b0;
    tick_a  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 10; j++) begin
        raw_a = 4'($urandom_range(0, 15));
        cyc();
      end
      check($sformatf("frozen_%0d", k), 16'(level_a), 16'h3);
    end

    // One-tick filter with a continuous tick: level follows 3 clocks after raw.
    for (int k = 0; k < 4; k++) begin
      old_b = level_b;
      raw_b = ~raw_b;
      q_b.push_back('{rise: {3'b000, raw_b[0]}, fall: {3'b000, ~raw_b[0]}});
      repeat (2) cyc();
      check($sformatf("b_hold_%0d", k), 16'(level_b), 16'(old_b));
      cyc();
      check($sformatf("b_follow_%0d", k), 16'(level_b), 16'(raw_b));
      repeat (2) cyc();
    end

    check("a_events_left", 16'(q_a.size()), 16'h0);
    check("b_events_left", 16'(q_b.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Conditions the raw board inputs (push button, splinker_switch, dripper_switch, selector) before they reach the mod-7 counter and the water-tank/irrigation FSMs. Per channel: 2-flop synchronizer, tick-based stability filter, registered rise/fall pulses. Sits directly upstream of the FSM stage. Runs on fast_clock and uses a sample tick derived from the clock definer.

Parameters:
WIDTH, 4, number of independent input channels
STABLE_TICKS, 8, consecutive sample ticks an input must differ from level_out before level_out changes (legal 1..15)
COUNT_W, 4, stability counter width; must satisfy 2^COUNT_W > STABLE_TICKS
RESET_LEVEL, 0, per-channel reset value of level_out and synchronizer flops; WIDTH-bit vector

Ports:
clock  input  1  block clock (fast_clock in the top level)
reset_pulse  input  1  asynchronous, active-low reset
sample_tick  input  1  one-clock-wide enable; the filter advances only on clocks where it is 1
raw_in  input  WIDTH  asynchronous raw inputs from switches and buttons
level_out  output  WIDTH  debounced, registered level per channel
rise_pulse  output  WIDTH  one-clock pulse when level_out goes 0->1
fall_pulse  output  WIDTH  one-clock pulse when level_out goes 1->0
changed  output  1  registered OR of all rise_pulse and fall_pulse bits, in the same cycle as those pulses

Behaviour:
- Reset is asynchronous, active-low, with immediate effect:
  - sync stage 1 and stage 2 = RESET_LEVEL
  - level_out = RESET_LEVEL
  - all counters = 0
  - rise_pulse = 0, fall_pulse = 0, changed = 0
- A reset asserted mid-count clears the count. No pulse is generated by reset or by reset release.
- The synchronizer samples raw_in every clock, regardless of sample_tick. Call its second-stage output sync.
- Each channel has a 2-state FSM, STABLE and CONFIRM, with counter cnt.
  - STABLE (cnt=0):
    - on sample_tick with sync != level_out: if STABLE_TICKS=1, commit; otherwise cnt=1 and go to CONFIRM.
    - otherwise hold.
  - CONFIRM:
    - on sample_tick with sync == level_out: cnt=0, go to STABLE. The glitch is rejected and no pulse is generated.
    - on sample_tick with sync != level_out and cnt == STABLE_TICKS-1: commit.
    - on sample_tick with sync != level_out and cnt < STABLE_TICKS-1: cnt = cnt+1.
    - with no tick: hold state and cnt.
- Commit sequence, all at one clock edge:
  - level_out toggles.
  - cnt = 0 and the channel returns to STABLE.
  - The matching rise_pulse or fall_pulse bit is 1 for exactly the next clock cycle, then 0.
  - changed is 1 in that same cycle.
- sync is compared only when sample_tick=1. Values of sync between ticks are ignored.
- Latency from a clean raw edge to level_out: 2 clocks (synchronizer) + STABLE_TICKS sample ticks, counting the first tick on which sync already differs.
- Channels are fully independent. Simultaneous commits on several channels assert several pulse bits in the same cycle; changed is asserted once.
- sample_tick held at 1 continuously is legal: the filter then counts clocks.
- sample_tick held at 0: level_out is frozen and no pulses are generated.
- cnt never exceeds STABLE_TICKS-1, so there is no wrap-around.
- rise_pulse and fall_pulse are never both 1 on the same channel.

Test Plan:
1. Reset values: WIDTH=4, RESET_LEVEL=4'b0000; assert reset_pulse=0 with raw_in=4'b1111 -> level_out=0, pulses=0, changed=0. Release reset with raw_in=0 -> no pulse for 50 clocks.
2. Clean edge: sample_tick every 4th clock, STABLE_TICKS=8; raw_in[1] 0->1 and held -> level_out[1] rises after 2 clocks + 8 ticks. rise_pulse[1]=1 and changed=1 for exactly 1 clock; all other bits stay 0.
3. Glitch rejection: raw_in[0] high for 7 ticks, then low -> level_out[0] stays 0 and no pulse. Then held high for 8 ticks -> level_out[0]=1 with a single rise_pulse[0].
4. Simultaneous events: raw_in[2] 0->1 and raw_in[3] 1->0 on the same clock, with level_out[3] initially 1 -> rise_pulse[2] and fall_pulse[3] on the same cycle; changed=1 for one clock only.
5. Reset mid-operation: raw_in[0]=1 for 5 ticks, then reset_pulse=0 for 1 clock, then released with raw_in[0] still 1 -> the count restarts. level_out[0] rises 8 ticks after the first post-reset tick on which sync differs, not after 3 ticks.
6. Boundaries:
   - STABLE_TICKS=1, sample_tick=1 continuous: raw toggle -> level_out follows 3 clocks after the raw edge.
   - sample_tick held at 0: raw toggles produce no change for 100 clocks.
